// File: rtl/simmem_wrsp_release_scheduler.sv
// Per-slot delay scheduler feeding the write-response bank's release interface.
// Optional protocol checking is enabled by defining SIMMEM_RELEASE_SCHED_ERR_EN.
module simmem_wrsp_release_scheduler #(
  parameter int Capa   = 16,
  parameter int IidW   = $clog2(Capa),
  parameter int DelayW = 6,
  parameter int CntW   = $clog2(Capa + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sched_valid_i,
  output logic              sched_ready_o,
  input  logic [IidW-1:0]   sched_iid_i,
  input  logic [DelayW-1:0] sched_delay_i,
  output logic [Capa-1:0]   release_en_o,
  input  logic [Capa-1:0]   released_addr_onehot_i,
  output logic [CntW-1:0]   num_pending_o,
  output logic              err_o
);

  // Handshake: a schedule request transfers on a clock edge where
  // sched_valid_i && sched_ready_o; ready depends only on the addressed slot's state.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_ELIGIBLE = 2'd2
  } slot_state_e;

  slot_state_e       state_q [Capa];
  slot_state_e       state_d [Capa];
  logic [DelayW-1:0] cnt_q   [Capa];
  logic [DelayW-1:0] cnt_d   [Capa];
  logic [CntW-1:0]   pending_q;
  logic [CntW-1:0]   pending_d;
  logic              accept;

  assign sched_ready_o = (state_q[sched_iid_i] == S_IDLE);
  assign accept        = sched_valid_i && sched_ready_o;
  assign num_pending_o = pending_q;

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < Capa; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (accept && (sched_iid_i == IidW'(i))) begin
            if (sched_delay_i == '0) begin
              state_d[i] = S_ELIGIBLE;
            end else begin
              state_d[i] = S_COUNTING;
              cnt_d[i]   = sched_delay_i;
            end
          end
        end
        S_COUNTING: begin
          cnt_d[i] = cnt_q[i] - DelayW'(1);
          if (cnt_q[i] == DelayW'(1)) begin
            state_d[i] = S_ELIGIBLE;
          end
        end
        S_ELIGIBLE: begin
          if (released_addr_onehot_i[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      // Counting the next states keeps the total exact even for multi-bit releases.
      if (state_d[i] != S_IDLE) begin
        pending_d = pending_d + CntW'(1);
      end
    end
  end

  always_comb begin
    release_en_o = '0;
    for (int i = 0; i < Capa; i++) begin
      release_en_o[i] = (state_q[i] == S_ELIGIBLE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Capa; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < Capa; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pending_q <= pending_d;
    end
  end

`ifdef SIMMEM_RELEASE_SCHED_ERR_EN
  logic err_q;
  logic bad_release;
  logic multi_release;
  logic bad_iid;

  assign bad_release   = |(released_addr_onehot_i & ~release_en_o);
  assign multi_release = |(released_addr_onehot_i & (released_addr_onehot_i - Capa'(1)));
  assign bad_iid       = sched_valid_i && ({1'b0, sched_iid_i} >= (IidW + 1)'(Capa));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (bad_release || multi_release || bad_iid) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_simmem_wrsp_release_scheduler.sv
// Bench for simmem_wrsp_release_scheduler: directed steps then random traffic,
// checked against a release-time model (slot busy + absolute release edge).
module tb_simmem_wrsp_release_scheduler;

  localparam int Capa   = 16;
  localparam int IidW   = 4;
  localparam int DelayW = 6;
  localparam int CntW   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sched_valid = 1'b0;
  logic              sched_ready;
  logic [IidW-1:0]   sched_iid = '0;
  logic [DelayW-1:0] sched_delay = '0;
  logic [Capa-1:0]   release_en;
  logic [Capa-1:0]   released = '0;
  logic [CntW-1:0]   num_pending;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a slot is busy from acceptance until release; it is
  // eligible once the edge count reaches its release edge.
  bit busy   [Capa];
  int rel_at [Capa];
  int edges  = 0;
  bit err_m  = 1'b0;

  simmem_wrsp_release_scheduler dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .sched_valid_i          (sched_valid),
    .sched_ready_o          (sched_ready),
    .sched_iid_i            (sched_iid),
    .sched_delay_i          (sched_delay),
    .release_en_o           (release_en),
    .released_addr_onehot_i (released),
    .num_pending_o          (num_pending),
    .err_o                  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [Capa-1:0] exp_en();
    logic [Capa-1:0] v = '0;
    for (int i = 0; i < Capa; i++) v[i] = busy[i] && (edges >= rel_at[i]);
    return v;
  endfunction

  function automatic int exp_pending();
    int n = 0;
    for (int i = 0; i < Capa; i++) n += int'(busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < Capa; i++) begin
      busy[i]   = 1'b0;
      rel_at[i] = 0;
    end
    err_m = 1'b0;
  endtask

  task automatic check_ready(input string tag);
    #1;
    check(tag, 32'(sched_ready), 32'(!busy[sched_iid]));
  endtask

  // One clock edge: advance the model from pre-edge inputs, then compare outputs.
  task automatic tick(input string tag);
    logic [Capa-1:0] en_now;
    bit acc;
    en_now = exp_en();
    acc    = sched_valid && !busy[sched_iid];
    if (!rst) begin
`ifdef SIMMEM_RELEASE_SCHED_ERR_EN
      if ((released & ~en_now) != '0 || (released & (released - 1'b1)) != '0) err_m = 1'b1;
`endif
      for (int i = 0; i < Capa; i++) begin
        if (released[i] && en_now[i]) busy[i] = 1'b0;
      end
      if (acc) begin
        busy[sched_iid]   = 1'b1;
        rel_at[sched_iid] = edges + 1 + int'(sched_delay);
      end
    end
    @(posedge clk);
    edges++;
    #1;
    check({tag, "_en"}, 32'(release_en), 32'(exp_en()));
    check({tag, "_pend"}, 32'(num_pending), 32'(exp_pending()));
    check({tag, "_err"}, 32'(err), 32'(err_m));
  endtask

  task automatic sched(input logic v, input int iid, input int d);
    sched_valid = v;
    sched_iid   = IidW'(iid);
    sched_delay = DelayW'(d);
  endtask

  initial begin
    logic [Capa-1:0] en;
    int start;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 32'(release_en), 32'h0);
    check("rst_pend", 32'(num_pending), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Zero delay: eligible right after the accept edge
    sched(1, 3, 0);
    check_ready("tp1_ready");
    tick("tp1_e0");
    check("tp1_en_lit", 32'(release_en), 32'h0008);
    sched(0, 0, 0);
    tick("tp1_e1");
    released = 16'h0008;
    tick("tp1_e2");
    released = '0;
    check("tp1_clr", 32'(release_en), 32'h0);

    // Delay 4: low through E3, high after E4
    sched(1, 5, 4);
    tick("tp2_e0");
    check("tp2_pend_lit", 32'(num_pending), 32'd1);
    sched(0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick("tp2_cnt");
      check("tp2_low", 32'(release_en[5]), 32'd0);
    end
    tick("tp2_e4");
    check("tp2_high", 32'(release_en[5]), 32'd1);
    released = 16'h0020;
    tick("tp2_rel");
    released = '0;

    // Two overlapping countdowns
    sched(1, 1, 6);
    tick("tp3_e0");
    sched(1, 2, 2);
    tick("tp3_e1");
    sched(0, 0, 0);
    for (int k = 2; k <= 8; k++) tick("tp3_run");
    check("tp3_both", 32'(release_en), 32'h0006);
    released = 16'h0004;
    tick("tp3_rel2");
    released = 16'h0002;
    tick("tp3_rel1");
    released = '0;

    // Busy slot refuses a new request until released
    sched(1, 7, 5);
    tick("tp4_acc");
    sched(1, 7, 3);
    check_ready("tp4_busy_ready");
    check("tp4_ready_lit", 32'(sched_ready), 32'd0);
    for (int k = 0; k < 5; k++) tick("tp4_wait");
    check("tp4_elig", 32'(release_en), 32'h0080);
    released = 16'h0080;
    tick("tp4_rel");
    released = '0;
    check_ready("tp4_ready_again");
    check("tp4_ready_lit2", 32'(sched_ready), 32'd1);
    tick("tp4_reacc");
    sched(0, 0, 0);
    for (int k = 0; k < 3; k++) tick("tp4_cnt2");
    check("tp4_elig2", 32'(release_en), 32'h0080);
    released = 16'h0080;
    tick("tp4_rel2");
    released = '0;

    // Asynchronous reset with three slots counting
    sched(1, 9, 10);
    tick("tp5_a");
    sched(1, 10, 20);
    tick("tp5_b");
    sched(1, 11, 30);
    tick("tp5_c");
    sched(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("tp5_async_en", 32'(release_en), 32'h0);
    check("tp5_async_pend", 32'(num_pending), 32'h0);
    model_clear();
    #1 rst = 1'b0;
    for (int k = 0; k < 35; k++) tick("tp5_after");

    // Random traffic with legal one-hot releases of eligible slots
    for (int k = 0; k < 400; k++) begin
      sched($urandom_range(0, 2) != 0, $urandom_range(0, Capa - 1),
            ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 12));
      released = '0;
      en = exp_en();
      if (en != '0 && $urandom_range(0, 1) == 1) begin
        start = $urandom_range(0, Capa - 1);
        for (int j = 0; j < Capa; j++) begin
          if (released == '0 && en[(start + j) % Capa]) released[(start + j) % Capa] = 1'b1;
        end
      end
      check_ready("rnd_ready");
      tick("rnd");
    end
    sched(0, 0, 0);
    released = '0;

    // Release of a non-eligible slot
    rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    tick("tp6_idle");
    released = 16'h0010;
    tick("tp6_bad");
    released = '0;
    tick("tp6_sticky");
`ifdef SIMMEM_RELEASE_SCHED_ERR_EN
    check("tp6_err_lit", 32'(err), 32'd1);
`else
    check("tp6_err_lit", 32'(err), 32'd0);
`endif
    sched(0, 4, 0);
    check_ready("tp6_slot4_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simmem_wrsp_release_scheduler.md
Name: simmem_wrsp_release_scheduler

Overview:
- Per-slot delay scheduler sitting directly upstream of the write-response bank's release interface.
- Takes (internal identifier, delay) entries from the write delay calculator and counts each slot's delay down independently.
- Drives the multi-hot release enable into the bank and frees each slot when the bank reports that slot's address released.

Parameters:
- Capa, 16, number of slots; equals write-response bank capacity (one slot per internal identifier).
- IidW, $clog2(Capa) = 4, internal identifier width.
- DelayW, 6, width of delay field in cycles.
- CntW, $clog2(Capa+1) = 5, width of pending-slot count.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- sched_valid_i  in  1  schedule request valid from delay calculator.
- sched_ready_o  out  1  schedule request ready.
- sched_iid_i  in  IidW  internal identifier (bank address) of response to schedule.
- sched_delay_i  in  DelayW  cycles to wait before release becomes enabled.
- release_en_o  out  Capa  multi-hot release enable to bank, one bit per address.
- released_addr_onehot_i  in  Capa  one-hot from bank: this address was released this cycle.
- num_pending_o  out  CntW  count of non-IDLE slots.
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Per-slot state: IDLE, COUNTING, ELIGIBLE; per-slot down-counter of DelayW bits.
- Reset (async, rst_i=1): all slots IDLE, counters 0, release_en_o=0, num_pending_o=0, err_o=0. Reset mid-count drops all pending entries immediately; no release is issued for them.
- sched_ready_o is combinational: 1 iff slot[sched_iid_i] is IDLE. It is independent of sched_valid_i. Upstream holds iid and delay stable while valid is high.
- Accept on an edge with sched_valid_i & sched_ready_o:
  - if sched_delay_i==0: slot goes to ELIGIBLE;
  - else: counter loads sched_delay_i and slot goes to COUNTING.
- COUNTING: counter decrements each edge. On the edge where counter==1, slot goes to ELIGIBLE and counter goes to 0.
- Timing: with acceptance on edge E0 and delay d, release_en_o[iid] is first high in the cycle after edge Ed (d=0 means right after E0).
- ELIGIBLE: release_en_o[i]=1, registered output with no combinational path from inputs. The bit stays high until released_addr_onehot_i[i] is sampled 1, after which the slot goes to IDLE on that edge.
- A slot released on edge E may be re-accepted on the next edge, since ready is computed from the current state. Same-edge release and accept of one slot cannot occur.
- All slots count concurrently. Any number of slots may be ELIGIBLE at once; ordering among them is the bank's responsibility.
- released_addr_onehot_i bit for a slot not in ELIGIBLE: ignored for state. With the macro enabled it sets err_o.
- num_pending_o is registered: +1 on accept, −1 on release. Both on the same edge (different slots) leaves it unchanged. Range 0..Capa, never wraps.
- Delay width: max delay 2^DelayW−1 = 63 cycles. No saturation is needed.

Optional Feature:
- Macro: SIMMEM_RELEASE_SCHED_ERR_EN.
- Defined: err_o is set (sticky until reset) on any of:
  - release of a non-ELIGIBLE slot;
  - released_addr_onehot_i not one-hot-or-zero;
  - sched_valid_i high while sched_iid_i ≥ Capa.
- Not defined: err_o tied to 0 and no checking logic is synthesised. The port exists in both builds.

Test Plan:
- Reset, then accept iid=3 delay=0 at E0 → release_en_o=16'h0008 from the cycle after E0. Pulse released bit 3 at E2 → release_en_o=0 and num_pending_o=0 after E2.
- Accept iid=5 delay=4 at E0 → release_en_o[5]=0 through E3, high after E4; num_pending_o=1 after E0.
- Accept iid=1 delay=6 at E0 and iid=2 delay=2 at E1 → bit 2 high after E3, bit 1 high after E6; both stay high until released.
- With iid=7 COUNTING, present sched_valid_i=1 with sched_iid_i=7 → sched_ready_o=0, no accept. Release 7 at En → ready=1 in the next cycle, re-accept succeeds.
- Assert rst_i asynchronously with 3 slots COUNTING → release_en_o=0, num_pending_o=0 immediately; no release after deassert.
- With macro defined: released_addr_onehot_i=16'h0010 while slot 4 IDLE → err_o=1 next cycle and stays 1. Without macro: err_o stays 0 and slot 4 is unchanged.
